// File: rtl/io_pkg.sv
// Shared opcode constants and sequencer state encoding for the I/O path.
// The control unit must decode the same opcode values.
package io_pkg;

  localparam logic [5:0] OP_IN   = 6'b001000;
  localparam logic [5:0] OP_OUT  = 6'b001001;
  localparam logic [5:0] OP_HALT = 6'b011001;

  typedef enum logic [2:0] {
    ST_RUN          = 3'd0,
    ST_WAIT_PRESS   = 3'd1,
    ST_WAIT_RELEASE = 3'd2,
    ST_COMMIT       = 3'd3,
    ST_HALTED       = 3'd4
  } io_state_t;

endpackage

// File: rtl/io_debounce.sv
// Button conditioner: two-flop synchronizer followed by a stability counter
// that flips the debounced level after DEBOUNCE_CYCLES disagreeing samples.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw_i,
  output logic btn_db_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive samples that disagree with the debounced level.
  always_comb begin
    db_d  = db_q;
    cnt_d = {CNT_W{1'b0}};
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d  = ~db_q;
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_db_o = db_q;

endmodule

// File: rtl/io_sequencer.sv
// I/O and halt sequencer: stalls the PC on IN until a debounced press/release,
// latches OUT data to the display and parks the core on HALT.
module io_sequencer
  import io_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int IN_W            = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic              confirm_btn,
  input  logic [IN_W-1:0]   switches,
  input  logic [DATA_W-1:0] out_data,
  output logic              pc_enable,
  output logic              in_valid,
  output logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] display,
  output logic              waiting_input,
  output logic              halted
);

  io_state_t         state_q;
  logic [DATA_W-1:0] in_data_q;
  logic [DATA_W-1:0] display_q;
  logic              in_valid_q;
  logic              waiting_q;
  logic              halted_q;
  logic              btn_db_s;
  logic [DATA_W-1:0] sw_ext_s;
  logic              stall_op_s;

  io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .reset    (reset),
    .btn_raw_i(confirm_btn),
    .btn_db_o (btn_db_s)
  );

  // Zero-extend the switch bank; also valid when IN_W equals DATA_W.
  always_comb begin
    sw_ext_s           = {DATA_W{1'b0}};
    sw_ext_s[IN_W-1:0] = switches;
  end

  assign stall_op_s = (opcode == OP_IN) || (opcode == OP_HALT);

  // PC enable follows the current state; during reset only the opcode matters.
  always_comb begin
    pc_enable = 1'b0;
    if (reset) begin
      pc_enable = ~stall_op_s;
    end else begin
      case (state_q)
        ST_RUN:    pc_enable = ~stall_op_s;
        ST_COMMIT: pc_enable = 1'b1;
        default:   pc_enable = 1'b0;
      endcase
    end
  end

  // Sequencer FSM with registered status outputs and data latches.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      in_data_q  <= {DATA_W{1'b0}};
      display_q  <= {DATA_W{1'b0}};
      in_valid_q <= 1'b0;
      waiting_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          in_valid_q <= 1'b0;
          if (opcode == OP_IN) begin
            state_q   <= ST_WAIT_PRESS;
            waiting_q <= 1'b1;
          end else if (opcode == OP_HALT) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else if (opcode == OP_OUT) begin
            display_q <= out_data;
          end
        end
        ST_WAIT_PRESS: begin
          if (btn_db_s) begin
            in_data_q <= sw_ext_s;
            state_q   <= ST_WAIT_RELEASE;
          end
        end
        // Requiring release makes one press feed exactly one IN.
        ST_WAIT_RELEASE: begin
          if (!btn_db_s) begin
            state_q    <= ST_COMMIT;
            in_valid_q <= 1'b1;
            waiting_q  <= 1'b0;
          end
        end
        ST_COMMIT: begin
          state_q    <= ST_RUN;
          in_valid_q <= 1'b0;
        end
        ST_HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_RUN;
          in_valid_q <= 1'b0;
          waiting_q  <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_valid      = in_valid_q;
  assign in_data       = in_data_q;
  assign display       = display_q;
  assign waiting_input = waiting_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_io_sequencer.sv
// Directed self-checking bench for io_sequencer with hand-computed expectations
// (DEBOUNCE_CYCLES = 4, IN_W = 16, DATA_W = 32).
module tb_io_sequencer;

  localparam logic [5:0] OP_IN   = 6'b001000;
  localparam logic [5:0] OP_OUT  = 6'b001001;
  localparam logic [5:0] OP_HALT = 6'b011001;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        confirm_btn;
  logic [15:0] switches;
  logic [31:0] out_data;
  logic        pc_enable;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] display;
  logic        waiting_input;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  io_sequencer #(
    .DATA_W(32),
    .IN_W(16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .confirm_btn  (confirm_btn),
    .switches     (switches),
    .out_data     (out_data),
    .pc_enable    (pc_enable),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .display      (display),
    .waiting_input(waiting_input),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int errs;
    int pulses;
    int first_j;
    int pc_on_pulse;

    reset       = 1'b1;
    opcode      = 6'd0;
    confirm_btn = 1'b0;
    switches    = 16'h0000;
    out_data    = 32'h0;
    step();
    step();

    // Reset state and pc_enable behaviour while reset is held.
    check_eq("rst_in_valid", {31'd0, in_valid}, 32'd0);
    check_eq("rst_display", display, 32'd0);
    check_eq("rst_in_data", in_data, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_waiting", {31'd0, waiting_input}, 32'd0);
    opcode = OP_IN;
    #1;
    check_eq("rst_pc_en_in", {31'd0, pc_enable}, 32'd0);
    opcode = 6'd2;
    #1;
    check_eq("rst_pc_en_other", {31'd0, pc_enable}, 32'd1);
    reset = 1'b0;

    // Pass-through opcodes.
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      opcode = (i == 0) ? 6'd0 : (i == 1) ? 6'd2 : 6'd6;
      #1;
      if (pc_enable !== 1'b1) errs++;
      step();
      if (in_valid !== 1'b0 || display !== 32'd0 || waiting_input !== 1'b0) errs++;
    end
    check_eq("passthru_errs", errs, 32'd0);

    // OUT: no stall, display updated on the edge where OUT is current.
    opcode   = OP_OUT;
    out_data = 32'h12345678;
    #1;
    check_eq("out_pc_en", {31'd0, pc_enable}, 32'd1);
    step();
    check_eq("out_display", display, 32'h12345678);
    opcode   = 6'd0;
    out_data = 32'hDEADBEEF;
    step();
    check_eq("out_display_hold", display, 32'h12345678);

    // IN with a clean 10-cycle press: first pulse 7 edges after release.
    opcode   = OP_IN;
    switches = 16'hBEEF;
    #1;
    check_eq("in_decode_pc_en", {31'd0, pc_enable}, 32'd0);
    step();
    check_eq("in_waiting", {31'd0, waiting_input}, 32'd1);
    opcode      = 6'd0;
    confirm_btn = 1'b1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pc_enable !== 1'b0 || in_valid !== 1'b0 || waiting_input !== 1'b1) errs++;
    end
    check_eq("in_press_stall_errs", errs, 32'd0);
    check_eq("in_data_latched", in_data, 32'h0000BEEF);
    switches    = 16'h0000;
    confirm_btn = 1'b0;
    pulses      = 0;
    first_j     = 0;
    pc_on_pulse = 0;
    errs        = 0;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (in_valid === 1'b1) begin
        pulses++;
        if (first_j == 0) begin
          first_j     = j;
          pc_on_pulse = int'(pc_enable);
        end
      end else if (first_j == 0 && pc_enable !== 1'b0) begin
        errs++;
      end
    end
    check_eq("in_pulse_count", pulses, 32'd1);
    check_eq("in_pulse_latency", first_j, 32'd7);
    check_eq("in_commit_pc_en", pc_on_pulse, 32'd1);
    check_eq("in_release_stall_errs", errs, 32'd0);
    check_eq("in_data_after", in_data, 32'h0000BEEF);
    check_eq("in_back_to_run", {31'd0, waiting_input}, 32'd0);

    // Glitches of 1..3 cycles must not leave WAIT_PRESS.
    opcode = OP_IN;
    step();
    opcode   = 6'd0;
    switches = 16'h1234;
    errs = 0;
    for (int g = 1; g <= 3; g++) begin
      confirm_btn = 1'b1;
      for (int i = 0; i < g; i++) begin
        step();
        if (waiting_input !== 1'b1 || in_valid !== 1'b0 || pc_enable !== 1'b0) errs++;
      end
      confirm_btn = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (waiting_input !== 1'b1 || in_valid !== 1'b0 || pc_enable !== 1'b0) errs++;
      end
    end
    check_eq("glitch_errs", errs, 32'd0);
    check_eq("glitch_in_data_unchanged", in_data, 32'h0000BEEF);

    // Real press reaches WAIT_RELEASE, then reset while still held.
    confirm_btn = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check_eq("wr_in_data", in_data, 32'h00001234);
    check_eq("wr_waiting", {31'd0, waiting_input}, 32'd1);
    reset = 1'b1;
    step();
    check_eq("wr_rst_waiting", {31'd0, waiting_input}, 32'd0);
    check_eq("wr_rst_in_data", in_data, 32'd0);
    check_eq("wr_rst_display", display, 32'd0);
    reset       = 1'b0;
    confirm_btn = 1'b0;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (in_valid !== 1'b0 || pc_enable !== 1'b1 || waiting_input !== 1'b0) errs++;
    end
    check_eq("wr_no_pulse_errs", errs, 32'd0);

    // HALT: everything ignored until reset.
    opcode   = OP_OUT;
    out_data = 32'hCAFEF00D;
    step();
    opcode = OP_HALT;
    #1;
    check_eq("halt_decode_pc_en", {31'd0, pc_enable}, 32'd0);
    step();
    check_eq("halt_halted", {31'd0, halted}, 32'd1);
    opcode   = OP_IN;
    out_data = 32'h0BADF00D;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      confirm_btn = ((i / 6) % 2) == 1;
      opcode      = (i < 15) ? OP_IN : OP_OUT;
      step();
      if (halted !== 1'b1 || pc_enable !== 1'b0 || in_valid !== 1'b0 || waiting_input !== 1'b0) errs++;
    end
    check_eq("halt_stuck_errs", errs, 32'd0);
    check_eq("halt_display_hold", display, 32'hCAFEF00D);
    confirm_btn = 1'b0;
    opcode      = 6'd0;
    reset       = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_eq("halt_rst_halted", {31'd0, halted}, 32'd0);
    check_eq("halt_rst_display", display, 32'd0);
    check_eq("halt_rst_pc_en", {31'd0, pc_enable}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
